// File: rtl/cordic_rotation_core.sv
// Iterative CORDIC shift-add engine fed by three 2:1 operand muxes, with start/done handshake.
// Define CORDIC_VECTORING_EN to add a `mode` input (1 = vectoring, 0 = rotation).

module mux #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             selection,
    output logic [WIDTH-1:0] out
);
    assign out = selection ? in2 : in1;
endmodule

module cordic_rotation_core #(
    parameter int FIXED_POINT = 16,
    parameter int ITERATIONS  = 16,
    parameter int ITER_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
`ifdef CORDIC_VECTORING_EN
    input  logic                          mode,
`endif
    input  logic signed [FIXED_POINT-1:0] x_in,
    input  logic signed [FIXED_POINT-1:0] y_in,
    input  logic signed [FIXED_POINT-1:0] z_in,
    output logic                          busy,
    output logic                          done,
    output logic signed [FIXED_POINT-1:0] x_out,
    output logic signed [FIXED_POINT-1:0] y_out,
    output logic signed [FIXED_POINT-1:0] z_out
);
    typedef enum logic [1:0] {IDLE, ROT, FIN} state_t;

    localparam int LSH = (FIXED_POINT >= 16) ? FIXED_POINT - 16 : 0;
    localparam int RSH = (FIXED_POINT < 16) ? 16 - FIXED_POINT : 0;
    localparam logic [ITER_W-1:0] LAST = ITER_W'(ITERATIONS - 1);

    // atan(2^-i) in Q3.13, rescaled to the configured fraction width
    function automatic logic signed [FIXED_POINT-1:0] atan_entry(input logic [ITER_W-1:0] i);
        int v;
        case (int'(i))
            0:       v = 6434;
            1:       v = 3798;
            2:       v = 2007;
            3:       v = 1019;
            4:       v = 511;
            5:       v = 256;
            6:       v = 128;
            7:       v = 64;
            8:       v = 32;
            9:       v = 16;
            10:      v = 8;
            11:      v = 4;
            12:      v = 2;
            13:      v = 1;
            default: v = 0;
        endcase
        v = (v <<< LSH) >>> RSH;
        return FIXED_POINT'(v);
    endfunction

    state_t                        state;
    logic [ITER_W-1:0]             cnt;
    logic                          sel;
    logic                          d_pos;
    logic signed [FIXED_POINT-1:0] x_fb, y_fb, z_fb;
    logic signed [FIXED_POINT-1:0] x_m, y_m, z_m;
    logic signed [FIXED_POINT-1:0] x_sh, y_sh, atan_i;
    logic signed [FIXED_POINT-1:0] x_nx, y_nx, z_nx;
`ifdef CORDIC_VECTORING_EN
    logic                          mode_r;
`endif

    // New operands pass through in IDLE; feedback registers recirculate otherwise
    assign sel = (state != IDLE);

    mux #(.WIDTH(FIXED_POINT)) u_mux_x (.in1(x_in), .in2(x_fb), .selection(sel), .out(x_m));
    mux #(.WIDTH(FIXED_POINT)) u_mux_y (.in1(y_in), .in2(y_fb), .selection(sel), .out(y_m));
    mux #(.WIDTH(FIXED_POINT)) u_mux_z (.in1(z_in), .in2(z_fb), .selection(sel), .out(z_m));

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        x_sh   = x_m >>> cnt;
        y_sh   = y_m >>> cnt;
        atan_i = atan_entry(cnt);
`ifdef CORDIC_VECTORING_EN
        d_pos  = mode_r ? y_m[FIXED_POINT-1] : ~z_m[FIXED_POINT-1];
`else
        d_pos  = ~z_m[FIXED_POINT-1];
`endif
        if (d_pos) begin
            x_nx = x_m - y_sh;
            y_nx = y_m + x_sh;
            z_nx = z_m - atan_i;
        end else begin
            x_nx = x_m + y_sh;
            y_nx = y_m - x_sh;
            z_nx = z_m + atan_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            x_fb  <= '0;
            y_fb  <= '0;
            z_fb  <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
`ifdef CORDIC_VECTORING_EN
            mode_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_fb  <= x_m;
                    y_fb  <= y_m;
                    z_fb  <= z_m;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ROT;
`ifdef CORDIC_VECTORING_EN
                    mode_r <= mode;
`endif
                end
                ROT: begin
                    x_fb <= x_nx;
                    y_fb <= y_nx;
                    z_fb <= z_nx;
                    cnt  <= cnt + ITER_W'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    x_out <= x_fb;
                    y_out <= y_fb;
                    z_out <= z_fb;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
